// File: rtl/pe_result_collector.sv
// PE array result collector: accumulates popcount chunks per neuron group,
// then emits thresholded XNOR activations and dot values.
module pe_result_collector #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int WORD_SIZE = 64,
  parameter int ACC_W     = 16,
  localparam int PCW      = $clog2(WORD_SIZE + 1),
  localparam int N        = ROWS * COLS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [N*PCW-1:0]   popcounts_in_flat,
  input  logic [PCW-1:0]     valid_bits_in,
  input  logic [N*ACC_W-1:0] thresholds_in_flat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       act_out,
  output logic [N*ACC_W-1:0] dot_out_flat
);

  localparam int AW = ACC_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t state;

  logic [AW-1:0] acc [N];
  logic [AW-1:0] nbits;

  logic accept;
  logic retire;

  logic [AW-1:0]      acc_nx [N];
  logic [AW-1:0]      nbits_nx;
  logic [N-1:0]       act_nx;
  logic [N*ACC_W-1:0] dot_nx;

  logic [PCW-1:0]          pop;
  logic [PCW-1:0]          pc;
  logic [AW-1:0]           base;
  logic [AW-1:0]           base_n;
  logic [AW:0]             sum;
  logic [AW:0]             nsum;
  logic signed [ACC_W:0]   d;
  logic signed [ACC_W-1:0] dc;
  logic signed [ACC_W-1:0] thr;

  assign in_ready = (state != HOLD);
  assign accept   = ce & in_valid & in_ready;
  assign retire   = ce & out_valid & out_ready;

  always_comb begin
    nbits_nx = '0;
    act_nx   = '0;
    dot_nx   = '0;
    pop      = '0;
    pc       = '0;
    base     = '0;
    sum      = '0;
    d        = '0;
    dc       = '0;
    thr      = '0;
    for (int i = 0; i < N; i++) acc_nx[i] = '0;
    // A fresh group starts from zero rather than stale partials.
    base_n   = (state == ACCUM) ? nbits : '0;
    nsum     = {1'b0, base_n}
             + {{(AW+1-PCW){1'b0}}, valid_bits_in};
    nbits_nx = nsum[AW] ? '1 : nsum[AW-1:0];
    for (int i = 0; i < N; i++) begin
      pop = popcounts_in_flat[i*PCW +: PCW];
      pc  = (pop > valid_bits_in) ? valid_bits_in : pop;
      base = (state == ACCUM) ? acc[i] : '0;
      sum  = {1'b0, base} + {{(AW+1-PCW){1'b0}}, pc};
      acc_nx[i] = sum[AW] ? '1 : sum[AW-1:0];
      d = $signed({1'b0, acc_nx[i], 1'b0})
        - $signed({2'b00, nbits_nx});
      // Top two bits disagree only when d leaves the ACC_W range.
      if (d[ACC_W] != d[ACC_W-1])
        dc = d[ACC_W] ? {1'b1, {AW{1'b0}}}
                      : {1'b0, {AW{1'b1}}};
      else
        dc = d[ACC_W-1:0];
      thr = thresholds_in_flat[i*ACC_W +: ACC_W];
      dot_nx[i*ACC_W +: ACC_W] = dc;
      act_nx[i] = (dc >= thr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      nbits        <= '0;
      out_valid    <= 1'b0;
      act_out      <= '0;
      dot_out_flat <= '0;
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (in_last) begin
              state        <= HOLD;
              out_valid    <= 1'b1;
              act_out      <= act_nx;
              dot_out_flat <= dot_nx;
              nbits        <= '0;
              for (int i = 0; i < N; i++) acc[i] <= '0;
            end else begin
              state <= ACCUM;
              nbits <= nbits_nx;
              for (int i = 0; i < N; i++) acc[i] <= acc_nx[i];
            end
          end
        end
        HOLD: begin
          if (retire) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector on a 2x2 array,
// 8-bit words and 8-bit signed dot/threshold width.
module tb_pe_result_collector;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int WS   = 8;
  localparam int AW   = 8;
  localparam int PCW  = 4;
  localparam int N    = ROWS * COLS;

  typedef struct packed {
    logic [N-1:0]    act;
    logic [N*AW-1:0] dot;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ce;
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [N*PCW-1:0] popcounts;
  logic [PCW-1:0]   valid_bits;
  logic [N*AW-1:0]  thresholds;
  logic out_valid;
  logic out_ready;
  logic [N-1:0]    act_out;
  logic [N*AW-1:0] dot_out_flat;

  exp_t sb[$];
  exp_t e;
  int   errors;
  int   checks;

  pe_result_collector #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .ACC_W(AW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ce                (ce),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_last           (in_last),
    .popcounts_in_flat (popcounts),
    .valid_bits_in     (valid_bits),
    .thresholds_in_flat(thresholds),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .act_out           (act_out),
    .dot_out_flat      (dot_out_flat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] p0, input logic [3:0] p1,
                       input logic [3:0] p2, input logic [3:0] p3,
                       input logic [3:0] vb, input logic last);
    popcounts  = {p3, p2, p1, p0};
    valid_bits = vb;
    in_last    = last;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (act_out !== 4'b0 || dot_out_flat !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got act=%b dot=%h want 0/0",
               act_out, dot_out_flat);
    end
  endtask

  task automatic test_single_beat();
    thresholds = 32'h0;
    sb.push_back('{act: 4'b1101, dot: 32'h02_00_F8_08});
    drive(4'd8, 4'd0, 4'd4, 4'd5, 4'd8, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got %b want 1", out_valid);
    end
    e = sb.pop_front();
    checks++;
    if (dot_out_flat !== e.dot) begin
      errors++;
      $display("FAIL single_dot got %h want %h", dot_out_flat, e.dot);
    end
    checks++;
    if (act_out !== e.act) begin
      errors++;
      $display("FAIL single_act got %b want %b", act_out, e.act);
    end
    retire();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_retire got v=%b r=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_multi_chunk();
    thresholds = {8'h00, 8'h00, 8'hED, 8'h14};
    sb.push_back('{act: 4'b0010, dot: 32'hED_ED_ED_13});
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL multi_in_ready beat %0d got %b want 1",
                 k, in_ready);
      end
      if (k < 2) drive(4'd8, 4'd0, 4'd0, 4'd0, 4'd8, 1'b0);
      else       drive(4'd3, 4'd0, 4'd0, 4'd0, 4'd3, 1'b1);
    end
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || dot_out_flat !== e.dot) begin
      errors++;
      $display("FAIL multi_dot got v=%b %h want 1 %h",
               out_valid, dot_out_flat, e.dot);
    end
    checks++;
    if (act_out !== e.act) begin
      errors++;
      $display("FAIL multi_act got %b want %b", act_out, e.act);
    end
    retire();
  endtask

  task automatic test_backpressure();
    thresholds = 32'h0;
    sb.push_back('{act: 4'b1111, dot: 32'h0});
    drive(4'd4, 4'd4, 4'd4, 4'd4, 4'd8, 1'b1);
    popcounts  = {4'd1, 4'd1, 4'd1, 4'd1};
    valid_bits = 4'd8;
    in_last    = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hs cyc %0d got v=%b r=%b want 1/0",
                 k, out_valid, in_ready);
      end
      checks++;
      if (dot_out_flat !== sb[0].dot || act_out !== sb[0].act) begin
        errors++;
        $display("FAIL bp_data cyc %0d got %b %h want %b %h", k,
                 act_out, dot_out_flat, sb[0].act, sb[0].dot);
      end
      tick();
    end
    e = sb.pop_front();
    sb.push_back('{act: 4'b0000, dot: 32'hFA_FA_FA_FA});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle got v=%b r=%b want 0/1",
               out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || dot_out_flat !== e.dot ||
        act_out !== e.act) begin
      errors++;
      $display("FAIL bp_held_beat got v=%b %b %h want 1 %b %h",
               out_valid, act_out, dot_out_flat, e.act, e.dot);
    end
    retire();
  endtask

  task automatic test_saturation();
    thresholds = 32'h0;
    sb.push_back('{act: 4'b1111, dot: 32'h7F_7F_7F_7F});
    for (int k = 0; k < 20; k++)
      drive(4'd8, 4'd8, 4'd8, 4'd8, 4'd8, k == 19);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || dot_out_flat !== e.dot ||
        act_out !== e.act) begin
      errors++;
      $display("FAIL sat_dot got v=%b %b %h want 1 %b %h",
               out_valid, act_out, dot_out_flat, e.act, e.dot);
    end
    retire();
    sb.push_back('{act: 4'b1111, dot: 32'h03_03_03_03});
    drive(4'd7, 4'd7, 4'd7, 4'd7, 4'd3, 1'b1);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || dot_out_flat !== e.dot) begin
      errors++;
      $display("FAIL clamp_dot got v=%b %h want 1 %h",
               out_valid, dot_out_flat, e.dot);
    end
    retire();
  endtask

  task automatic test_ce_gating();
    thresholds = 32'h0;
    drive(4'd2, 4'd2, 4'd2, 4'd2, 4'd8, 1'b0);
    ce         = 1'b0;
    popcounts  = {4'd8, 4'd8, 4'd8, 4'd8};
    valid_bits = 4'd8;
    in_last    = 1'b1;
    in_valid   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL ce_in cyc %0d got v=%b r=%b want 0/1",
                 k, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ce = 1'b1;
    sb.push_back('{act: 4'b0000, dot: 32'hFC_FC_FC_FC});
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || dot_out_flat !== e.dot) begin
      errors++;
      $display("FAIL ce_acc got v=%b %h want 1 %h",
               out_valid, dot_out_flat, e.dot);
    end
    ce = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || dot_out_flat !== e.dot) begin
        errors++;
        $display("FAIL ce_out cyc %0d got v=%b %h want 1 %h",
                 k, out_valid, dot_out_flat, e.dot);
      end
    end
    ce = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ce_retire got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_group();
    thresholds = 32'h0;
    drive(4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 1'b0);
    drive(4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_hs got v=%b r=%b want 0/1",
               out_valid, in_ready);
    end
    sb.push_back('{act: 4'b0000, dot: 32'hFC_FC_FC_FC});
    drive(4'd2, 4'd2, 4'd2, 4'd2, 4'd8, 1'b1);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || dot_out_flat !== e.dot ||
        act_out !== e.act) begin
      errors++;
      $display("FAIL rstmid_dot got v=%b %b %h want 1 %b %h",
               out_valid, act_out, dot_out_flat, e.act, e.dot);
    end
    retire();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    ce         = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    popcounts  = '0;
    valid_bits = '0;
    thresholds = '0;
    out_ready  = 1'b0;
    tick();
    test_reset();
    test_single_beat();
    test_multi_chunk();
    test_backpressure();
    test_saturation();
    test_ce_gating();
    test_reset_mid_group();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
Consumer end of the PE array. Takes the flat per-PE popcount bus produced each array cycle and accumulates it over a variable number of K-chunks per output neuron group. On the last chunk it converts each sum to a signed XNOR dot product (2*pop - nbits), compares it to a per-PE threshold, and presents the packed binary activations plus dot values through a valid/ready output stage.

Parameters:
ROWS, 8, PE rows; must match the array.
COLS, 8, PE columns; must match the array.
WORD_SIZE, 64, bits per PE word; sets PCW = $clog2(WORD_SIZE+1).
ACC_W, 16, signed width of thresholds and dot outputs; unsigned accumulators are ACC_W-1 bits.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ce  in  1  clock enable; all state and handshakes are frozen when 0
in_valid  in  1  popcount beat valid
in_ready  out  1  collector can accept a beat
in_last  in  1  beat is the final chunk of the group
popcounts_in_flat  in  ROWS*COLS*PCW  per-PE popcounts; PE i at [(i+1)*PCW-1 : i*PCW]
valid_bits_in  in  PCW  unmasked bit count of this chunk, common to all PEs
thresholds_in_flat  in  ROWS*COLS*ACC_W  signed per-PE thresholds; sampled on the last beat
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
act_out  out  ROWS*COLS  bit i = (dot_i >= thr_i)
dot_out_flat  out  ROWS*COLS*ACC_W  signed dot product per PE

Behaviour:
- accept = ce & in_valid & in_ready. retire = ce & out_valid & out_ready.
- FSM states are IDLE, ACCUM and HOLD. in_ready = (state != HOLD), combinational.
- IDLE, accept & !in_last: go to ACCUM. acc_i = pc_i, nbits = valid_bits_in.
- IDLE or ACCUM, accept & in_last: go to HOLD. Compute the result from acc+beat, register it, clear the accumulators.
- ACCUM, accept & !in_last: stay. acc_i += pc_i, nbits += valid_bits_in.
- HOLD, retire: go to IDLE. No beat is accepted in the retire cycle because in_ready = 0.
- Latency: last beat accepted at edge t, out_valid = 1 after edge t (visible cycle t+1).
- Operand clamp: pc_i = min(popcount_i, valid_bits_in).
- Accumulator arithmetic: acc_i and nbits are unsigned ACC_W-1 bits and saturate at 2^(ACC_W-1)-1. No wrap.
- Dot arithmetic: dot_i = 2*acc_i - nbits, computed in ACC_W+1 signed and clamped to the signed ACC_W range. Thresholds are compared signed.
- Output stability: act_out, dot_out_flat and out_valid are registered and held stable while out_valid & !out_ready, or while ce = 0.
- Input stall: in_valid with in_ready = 0 has no effect. The beat is not consumed, and the upstream source must hold it.
- Reset (any state, including mid-accumulation or HOLD): state = IDLE, acc_i = 0, nbits = 0, out_valid = 0, act_out = 0, dot_out_flat = 0. Partial sums and any pending result are discarded. in_ready = 1 in the first cycle after reset.
- ce = 0: no state change and no accept/retire, even when in_valid or out_ready is high. Outputs hold.

Test Plan:
Bench parameters: ROWS=2, COLS=2, WORD_SIZE=8 (PCW=4), ACC_W=8.
1. Single beat: popcounts {8,0,4,5}, valid_bits 8, last, thr all 0. Next cycle: out_valid=1, dot={8,-8,0,2}, act_out=4'b1101 (PE0 at LSB).
2. Three beats, valid_bits 8,8,3; PE0 pops 8,8,3; PE1 pops 0,0,0; thr PE0=20, PE1=-19. Result: dot0=19, act0=0; dot1=-19, act1=1. in_ready=1 throughout.
3. Backpressure: after the result, hold out_ready=0 for 5 cycles while driving in_valid. Required: out_valid and data stable, in_ready=0, no beat consumed. Raise out_ready: state goes to IDLE next cycle and the held beat is accepted the cycle after.
4. Saturation and clamp: 20 beats of pop 8 / valid 8 give acc=nbits=127 and dot=127. Separately, a beat with pop 7 / valid 3 / last gives dot=3.
5. ce gating: in_valid=1 with ce=0 for 3 cycles leaves acc unchanged. out_ready=1 with ce=0 does not clear out_valid.
6. Reset mid-group: after 2 non-last beats, pulse rst_n=0 for one cycle; out_valid=0 and in_ready=1 afterwards. Then one beat of pop 2 / valid 8 / last gives dot=-4 (prior partials are not included).
